// File: rtl/counter_sequencer.sv
// Control sequencer for the free-running counter core: gates enable/clear, detects
// period match, runs one-shot or periodic. Optional prescaler: COUNTER_SEQ_PRESCALE_EN.
module counter_sequencer #(
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 16,
    parameter int WRAP_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_clear,
    input  logic              cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [PRE_W-1:0]  cfg_prescale,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic              irq,
    input  logic              irq_ack,
    output logic [1:0]        state,
    output logic              busy,
    output logic [WRAP_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    seq_state_t        state_r;
    seq_state_t        next_s;
    logic              irq_r;
    logic [WRAP_W-1:0] wrap_r;
    logic              tick_s;
    logic              match_s;
    logic              period_nz_s;
    logic              en_s;
    logic              clr_s;
    logic              wrap_clr_s;
    logic              pre_clr_s;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRE_W-1:0]  pre_r;

    assign tick_s = (pre_r == cfg_prescale);

    // Prescaler: advances only while running, frozen in PAUSE, zeroed on (re)start and clear.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (pre_clr_s) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            if (tick_s) begin
                pre_r <= {PRE_W{1'b0}};
            end else begin
                pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_r <= pre_r;
        end
    end
`else
    logic unused_prescale_s;

    assign unused_prescale_s = ^{cfg_prescale, pre_clr_s};
    assign tick_s            = 1'b1;
`endif

    assign period_nz_s = (cfg_period != {CNT_W{1'b0}});
    assign match_s     = (state_r == ST_RUN) && tick_s && (cnt_value == (cfg_period - CNT_ONE));

    // Next-state and counter-control decode; clear beats stop beats start.
    always_comb begin
        next_s     = state_r;
        en_s       = 1'b0;
        clr_s      = 1'b0;
        wrap_clr_s = 1'b0;
        pre_clr_s  = 1'b0;
        if (cmd_clear) begin
            clr_s      = 1'b1;
            wrap_clr_s = 1'b1;
            pre_clr_s  = 1'b1;
            next_s     = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (cmd_start && !cmd_stop && period_nz_s) begin
                        clr_s     = 1'b1;
                        pre_clr_s = 1'b1;
                        next_s    = ST_RUN;
                    end else begin
                        next_s = state_r;
                    end
                end
                ST_RUN: begin
                    en_s = tick_s && !cmd_stop;
                    if (match_s) begin
                        if (cfg_mode) begin
                            clr_s  = 1'b1;
                            next_s = cmd_stop ? ST_PAUSE : ST_RUN;
                        end else begin
                            next_s = ST_DONE;
                        end
                    end else if (cmd_stop) begin
                        next_s = ST_PAUSE;
                    end else begin
                        next_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (cmd_start && !cmd_stop) begin
                        next_s = ST_RUN;
                    end else begin
                        next_s = ST_PAUSE;
                    end
                end
                default: begin
                    next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Sticky interrupt: a new match wins over a same-cycle acknowledge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            irq_r <= 1'b0;
        end else if (match_s) begin
            irq_r <= 1'b1;
        end else if (irq_ack) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    // Saturating tally of completed periods.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wrap_r <= {WRAP_W{1'b0}};
        end else if (wrap_clr_s) begin
            wrap_r <= {WRAP_W{1'b0}};
        end else if (match_s && (wrap_r != WRAP_MAX)) begin
            wrap_r <= wrap_r + WRAP_ONE;
        end else begin
            wrap_r <= wrap_r;
        end
    end

    // Core controls are masked by reset so they drop immediately, independent of the clock.
    assign cnt_en     = en_s & ARESETn;
    assign cnt_clr    = clr_s & ARESETn;
    assign state      = state_r;
    assign busy       = (state_r == ST_RUN);
    assign irq        = irq_r;
    assign wrap_count = wrap_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: vector table, directed corner sequences,
// and randomized commands against a cycle-level reference model.
module tb_counter_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        cfg_mode = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic [15:0] cfg_prescale = 16'd0;
    logic [31:0] cnt_value;
    logic        cnt_clr;
    logic        cnt_en;
    logic        irq;
    logic        irq_ack = 1'b0;
    logic [1:0]  state;
    logic        busy;
    logic [7:0]  wrap_count;

    int total = 0;
    int bad = 0;

    // reference model state: 0 idle, 1 run, 2 pause, 3 done
    int          m_state;
    bit          m_irq;
    int          m_wrap;
    int          m_pre;
    logic [31:0] m_cnt;

    counter_sequencer #(.CNT_W(32), .PRE_W(16), .WRAP_W(8)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_clear(cmd_clear),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_prescale(cfg_prescale),
        .cnt_value(cnt_value), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .irq(irq), .irq_ack(irq_ack), .state(state), .busy(busy),
        .wrap_count(wrap_count)
    );

    always #5 ACLK = ~ACLK;

    // counter core stand-in: clear has priority over enable
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) cnt_value <= 32'd0;
        else if (cnt_clr) cnt_value <= 32'd0;
        else if (cnt_en) cnt_value <= cnt_value + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_irq = 1'b0; m_wrap = 0; m_pre = 0; m_cnt = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        m_reset();
    endtask

    // One clock: drive commands, predict from the model, check before and after the edge.
    task automatic step(input bit st, input bit sp, input bit cl, input bit ak,
                        output bit o_en, output bit o_clr);
        bit tick, hit, e_en, e_clr, idle_like;
        int ns;
        @(negedge ACLK);
        cmd_start = st; cmd_stop = sp; cmd_clear = cl; irq_ack = ak;
        #1;
`ifdef COUNTER_SEQ_PRESCALE_EN
        tick = (m_state == 1) && (m_pre == int'(cfg_prescale));
`else
        tick = 1'b1;
`endif
        idle_like = (m_state == 0) || (m_state == 3);
        hit   = (m_state == 1) && tick && (m_cnt == cfg_period - 32'd1);
        e_clr = cl || (idle_like && st && !sp && cfg_period != 32'd0)
                   || (m_state == 1 && hit && cfg_mode);
        e_en  = !cl && (m_state == 1) && tick && !sp;
        check("cnt_en", cnt_en, e_en);
        check("cnt_clr", cnt_clr, e_clr);
        o_en = cnt_en; o_clr = cnt_clr;
        if (cl) ns = 0;
        else if (idle_like) ns = (st && !sp && cfg_period != 32'd0) ? 1 : m_state;
        else if (m_state == 1) ns = hit ? (cfg_mode ? (sp ? 2 : 1) : 3) : (sp ? 2 : 1);
        else ns = (st && !sp) ? 1 : 2;
        if (hit) m_irq = 1'b1; else if (ak) m_irq = 1'b0;
        if (cl) m_wrap = 0; else if (hit && m_wrap < 255) m_wrap++;
        if (cl || (idle_like && ns == 1)) m_pre = 0;
        else if (m_state == 1) m_pre = tick ? 0 : m_pre + 1;
        if (e_clr) m_cnt = 32'd0; else if (e_en) m_cnt = m_cnt + 32'd1;
        m_state = ns;
        @(posedge ACLK);
        #1;
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0; irq_ack = 1'b0;
        check("state", {30'd0, state}, m_state);
        check("busy", busy, m_state == 1);
        check("irq", irq, m_irq);
        check("wrap_count", {24'd0, wrap_count}, m_wrap);
        check("cnt_value", cnt_value, m_cnt);
    endtask

    typedef struct {
        bit          st, sp, cl, ak, mode;
        logic [31:0] period;
        bit          e_en, e_clr;
        logic [1:0]  e_state;
        bit          e_irq;
        logic [7:0]  e_wrap;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[17];

    initial begin
        bit en_o, clr_o;
        int n, n_en;

        vecs[0]  = '{1,0,0,0,0,32'd3, 0,1, 2'd1,0,8'd0,32'd0};
        vecs[1]  = '{0,0,0,0,0,32'd3, 1,0, 2'd1,0,8'd0,32'd1};
        vecs[2]  = '{0,0,0,0,0,32'd3, 1,0, 2'd1,0,8'd0,32'd2};
        vecs[3]  = '{0,0,0,0,0,32'd3, 1,0, 2'd3,1,8'd1,32'd3};
        vecs[4]  = '{0,0,0,0,0,32'd3, 0,0, 2'd3,1,8'd1,32'd3};
        vecs[5]  = '{0,0,0,1,0,32'd3, 0,0, 2'd3,0,8'd1,32'd3};
        vecs[6]  = '{1,0,0,0,1,32'd2, 0,1, 2'd1,0,8'd1,32'd0};
        vecs[7]  = '{0,0,0,0,1,32'd2, 1,0, 2'd1,0,8'd1,32'd1};
        vecs[8]  = '{0,0,0,0,1,32'd2, 1,1, 2'd1,1,8'd2,32'd0};
        vecs[9]  = '{0,0,0,0,1,32'd2, 1,0, 2'd1,1,8'd2,32'd1};
        vecs[10] = '{0,0,0,1,1,32'd2, 1,1, 2'd1,1,8'd3,32'd0};
        vecs[11] = '{0,1,0,0,1,32'd2, 0,0, 2'd2,1,8'd3,32'd0};
        vecs[12] = '{0,0,0,0,1,32'd2, 0,0, 2'd2,1,8'd3,32'd0};
        vecs[13] = '{1,0,0,0,1,32'd2, 0,0, 2'd1,1,8'd3,32'd0};
        vecs[14] = '{0,0,1,0,1,32'd2, 0,1, 2'd0,1,8'd0,32'd0};
        vecs[15] = '{1,0,0,0,1,32'd0, 0,0, 2'd0,1,8'd0,32'd0};
        vecs[16] = '{0,1,0,0,1,32'd0, 0,0, 2'd0,1,8'd0,32'd0};

        do_reset();
        #1;
        check("reset state", {30'd0, state}, 32'd0);
        check("reset irq", irq, 32'd0);
        check("reset wrap", {24'd0, wrap_count}, 32'd0);
        check("reset en", cnt_en, 32'd0);
        check("reset clr", cnt_clr, 32'd0);
        check("reset busy", busy, 32'd0);

        for (int i = 0; i < 17; i++) begin
            cfg_mode = vecs[i].mode; cfg_period = vecs[i].period;
            step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].ak, en_o, clr_o);
            check($sformatf("vec%0d en", i), en_o, vecs[i].e_en);
            check($sformatf("vec%0d clr", i), clr_o, vecs[i].e_clr);
            check($sformatf("vec%0d state", i), {30'd0, state}, vecs[i].e_state);
            check($sformatf("vec%0d irq", i), irq, vecs[i].e_irq);
            check($sformatf("vec%0d wrap", i), {24'd0, wrap_count}, vecs[i].e_wrap);
            check($sformatf("vec%0d cnt", i), cnt_value, vecs[i].e_cnt);
        end

        // one-shot period 10
        cfg_mode = 1'b0; cfg_period = 32'd10;
        step(0, 0, 0, 1, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        check("os10 start clr", clr_o, 32'd1);
        n_en = 0; n = 0;
        while (state != 2'd3 && n < 40) begin
            step(0, 0, 0, 0, en_o, clr_o);
            if (en_o) n_en++;
            n++;
        end
        check("os10 en cycles", n_en, 32'd10);
        check("os10 state", {30'd0, state}, 32'd3);
        check("os10 cnt", cnt_value, 32'd10);
        check("os10 irq", irq, 32'd1);
        check("os10 wrap", {24'd0, wrap_count}, 32'd1);

        // periodic period 4 for 13 cycles
        cfg_mode = 1'b1; cfg_period = 32'd4;
        step(0, 0, 1, 1, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        for (int k = 1; k <= 13; k++) begin
            step(0, 0, 0, 0, en_o, clr_o);
            check($sformatf("per4 cnt k=%0d", k), cnt_value, k % 4);
        end
        check("per4 wrap", {24'd0, wrap_count}, 32'd3);
        check("per4 irq held", irq, 32'd1);
        step(0, 0, 0, 1, en_o, clr_o);
        check("per4 irq acked", irq, 32'd0);

        // pause at 5 and resume without clear
        cfg_mode = 1'b0; cfg_period = 32'd20;
        step(0, 0, 1, 0, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        repeat (5) step(0, 0, 0, 0, en_o, clr_o);
        step(0, 1, 0, 0, en_o, clr_o);
        check("pause state", {30'd0, state}, 32'd2);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, en_o, clr_o);
            check("pause hold", cnt_value, 32'd5);
        end
        step(1, 0, 0, 0, en_o, clr_o);
        check("resume no clr", clr_o, 32'd0);
        check("resume cnt", cnt_value, 32'd5);
        step(0, 0, 0, 0, en_o, clr_o);
        check("resume count", cnt_value, 32'd6);

        // stop coinciding with one-shot match
        cfg_mode = 1'b0; cfg_period = 32'd3;
        step(0, 0, 1, 1, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        repeat (2) step(0, 0, 0, 0, en_o, clr_o);
        step(0, 1, 0, 0, en_o, clr_o);
        check("stop+match state", {30'd0, state}, 32'd3);
        check("stop+match irq", irq, 32'd1);

        // ack coinciding with a periodic match
        cfg_mode = 1'b1; cfg_period = 32'd2;
        step(0, 0, 1, 1, en_o, clr_o);
        check("ack cleared irq", irq, 32'd0);
        step(1, 0, 0, 0, en_o, clr_o);
        step(0, 0, 0, 0, en_o, clr_o);
        step(0, 0, 0, 1, en_o, clr_o);
        check("ack+match irq", irq, 32'd1);

        // clear in RUN at 7, then start with zero period
        cfg_mode = 1'b1; cfg_period = 32'd20;
        step(0, 0, 1, 0, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        repeat (7) step(0, 0, 0, 0, en_o, clr_o);
        check("pre-clear cnt", cnt_value, 32'd7);
        step(0, 0, 1, 0, en_o, clr_o);
        check("clear pulse", clr_o, 32'd1);
        check("clear state", {30'd0, state}, 32'd0);
        check("clear wrap", {24'd0, wrap_count}, 32'd0);
        cfg_period = 32'd0;
        step(1, 0, 0, 0, en_o, clr_o);
        check("zero period start", {30'd0, state}, 32'd0);

`ifdef COUNTER_SEQ_PRESCALE_EN
        cfg_mode = 1'b0; cfg_period = 32'd3; cfg_prescale = 16'd2;
        step(1, 0, 0, 0, en_o, clr_o);
        n_en = 0; n = 0;
        while (state != 2'd3 && n < 40) begin
            step(0, 0, 0, 0, en_o, clr_o);
            if (en_o) n_en++;
            n++;
        end
        check("pre cycles to done", n, 32'd9);
        check("pre en pulses", n_en, 32'd3);
        check("pre done cnt", cnt_value, 32'd3);
        cfg_prescale = 16'd0;
`endif

        // asynchronous reset mid-run with irq and wrap_count set
        cfg_mode = 1'b1; cfg_period = 32'd2;
        step(0, 0, 1, 0, en_o, clr_o);
        step(1, 0, 0, 0, en_o, clr_o);
        repeat (5) step(0, 0, 0, 0, en_o, clr_o);
        check("pre-reset irq", irq, 32'd1);
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        check("async rst en", cnt_en, 32'd0);
        check("async rst clr", cnt_clr, 32'd0);
        check("async rst state", {30'd0, state}, 32'd0);
        check("async rst busy", busy, 32'd0);
        check("async rst irq", irq, 32'd0);
        check("async rst wrap", {24'd0, wrap_count}, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        m_reset();

        // randomized commands against the model
        for (int r = 0; r < 3000; r++) begin
            if (m_state != 1 && $urandom_range(0, 3) == 0) begin
                cfg_period   = $urandom_range(0, 6);
                cfg_mode     = 1'($urandom_range(0, 1));
                cfg_prescale = 16'($urandom_range(0, 2));
            end
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, en_o, clr_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
